// File: rtl/decode_imm_ctrl_if.sv
// Fetch-to-decode handshake bundle for decode_imm_ctrl: upstream valid/ready,
// flush, and the decoded head entry presented to the immediate extender.
interface decode_imm_ctrl_if #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned IMM_WIDTH   = 25,
    parameter int unsigned PC_WIDTH    = 64
);
    logic                   i_flush;
    logic                   i_valid;
    logic                   o_ready;
    logic [INSTR_WIDTH-1:0] i_instr;
    logic [PC_WIDTH-1:0]    i_pc;
    logic                   o_valid;
    logic                   i_ready;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic [PC_WIDTH-1:0]    o_pc;
    logic [IMM_WIDTH-1:0]   o_imm;
    logic [2:0]             o_imm_ctrl;
    logic                   o_imm_used;
    logic                   o_illegal;

    modport slave (
        input  i_flush, i_valid, i_instr, i_pc, i_ready,
        output o_ready, o_valid, o_instr, o_pc, o_imm, o_imm_ctrl, o_imm_used, o_illegal
    );

    modport master (
        output i_flush, i_valid, i_instr, i_pc, i_ready,
        input  o_ready, o_valid, o_instr, o_pc, o_imm, o_imm_ctrl, o_imm_used, o_illegal
    );
endinterface

// File: rtl/decode_imm_ctrl.sv
// Decode-side immediate-format controller with a 2-entry skid buffer.
// Optional per-format pop counters are enabled with `define DECODE_IMM_STATS_EN.
module decode_imm_ctrl #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned IMM_WIDTH   = 25,
    parameter int unsigned PC_WIDTH    = 64
) (
    input  logic              i_clk,
    input  logic              i_arst,
`ifdef DECODE_IMM_STATS_EN
    input  logic [2:0]        i_stat_sel,
    output logic [31:0]       o_stat_cnt,
`endif
    decode_imm_ctrl_if.slave  bus
);
    localparam int unsigned NUM_STATS = 6;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
        logic [2:0]             ctrl;
        logic                   used;
        logic                   illegal;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, skid_q;
    logic   valid_q, ready_q;
    logic   accept, pop;
    logic   load_head, load_skid, shift_skid;
    entry_t in_entry;

    // Classify immediate format from the opcode at capture time.
    function automatic entry_t decode(input logic [INSTR_WIDTH-1:0] instr,
                                      input logic [PC_WIDTH-1:0] pc);
        entry_t e;
        e.instr   = instr;
        e.pc      = pc;
        e.ctrl    = 3'b000;
        e.used    = 1'b1;
        e.illegal = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b1110011:             e.ctrl = 3'b000;
            7'b0100011:                         e.ctrl = 3'b001;
            7'b1100011:                         e.ctrl = 3'b010;
            7'b1101111:                         e.ctrl = 3'b011;
            7'b0110111, 7'b0010111:             e.ctrl = 3'b100;
            7'b0110011, 7'b0111011, 7'b0001111: e.used = 1'b0;
            default: begin
                e.ctrl    = 3'b111;
                e.used    = 1'b0;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    assign in_entry = decode(bus.i_instr, bus.i_pc);
    assign accept   = bus.i_valid & ready_q;
    assign pop      = valid_q & bus.i_ready;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != EMPTY);
            ready_q <= (state_d != FULL);
        end
    end

    // Flush wins over any accept or pop in the same cycle.
    always_comb begin
        state_d    = state_q;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        if (bus.i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        load_head = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (accept && pop) begin
                        load_head = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d    = ONE;
                        shift_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head) begin
                head_q <= in_entry;
            end else if (shift_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_instr    = head_q.instr;
    assign bus.o_pc       = head_q.pc;
    assign bus.o_imm      = head_q.instr[INSTR_WIDTH-1:INSTR_WIDTH-IMM_WIDTH];
    assign bus.o_imm_ctrl = head_q.ctrl;
    assign bus.o_imm_used = head_q.used;
    assign bus.o_illegal  = head_q.illegal;

`ifdef DECODE_IMM_STATS_EN
    logic [31:0] cnt_q [NUM_STATS];
    logic [2:0]  pop_cls;
    logic        pop_counted;

    // Illegal entries share slot 5; immediate-less legal ops are not counted.
    assign pop_cls     = head_q.illegal ? 3'd5 : head_q.ctrl;
    assign pop_counted = pop & (head_q.used | head_q.illegal);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int k = 0; k < NUM_STATS; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_STATS; k++) begin
                if (pop_counted && (pop_cls == 3'(k)) && (cnt_q[k] != 32'hFFFF_FFFF)) begin
                    cnt_q[k] <= cnt_q[k] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        o_stat_cnt = '0;
        for (int k = 0; k < NUM_STATS; k++) begin
            if (i_stat_sel == 3'(k)) o_stat_cnt = cnt_q[k];
        end
    end
`endif
endmodule

// File: doc/decode_imm_ctrl.md
Name: decode_imm_ctrl

Overview:
Decode-side controller that sequences the immediate-extension datapath in the RV64 core pipeline.
- Accepts fetched instructions over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Classifies each instruction's immediate format from its opcode.
- Presents the raw 25-bit immediate field plus the 3-bit format select to the immediate extender, together with the instruction and PC, to the decode/execute boundary.

Parameters:
- INSTR_WIDTH, 32, instruction width.
- IMM_WIDTH, 25, raw immediate field width (instr[31:7]).
- PC_WIDTH, 64, program counter width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_arst  in  1  asynchronous active-high reset.
- i_flush  in  1  discard all buffered entries (branch redirect / trap).
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  buffer can accept (registered).
- i_instr  in  INSTR_WIDTH  fetched instruction.
- i_pc  in  PC_WIDTH  PC of i_instr.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts head.
- o_instr  out  INSTR_WIDTH  head instruction.
- o_pc  out  PC_WIDTH  head PC.
- o_imm  out  IMM_WIDTH  head instr[31:7], to extender immediate input.
- o_imm_ctrl  out  3  extender format select.
- o_imm_used  out  1  head instruction has an immediate operand.
- o_illegal  out  1  head opcode unrecognised.

Behaviour:
- Reset (async, i_arst=1): state EMPTY; o_valid=0, o_ready=1 (asserted once reset is released), o_instr/o_pc/o_imm=0, o_imm_ctrl=3'b000, o_imm_used=0, o_illegal=0. Reset mid-transfer drops all entries.
- Storage: head register (drives outputs) plus skid register. Decode is performed at capture, and each entry stores instr, pc, ctrl, used, illegal. All outputs are register outputs, with no combinational path from input to output.
- accept = i_valid & o_ready; pop = o_valid & i_ready. Latency: an instruction accepted at edge N appears on the outputs after edge N (1 cycle).
- State transitions:
  - EMPTY: accept -> ONE (load head).
  - ONE: accept & ~pop -> FULL (load skid). pop & ~accept -> EMPTY. accept & pop -> ONE (head loads new entry).
  - FULL: pop -> ONE (head <= skid). No accept is possible (o_ready=0).
- o_ready = (state != FULL). o_valid = (state != EMPTY). FIFO order is always preserved.
- Holding: while o_valid & ~i_ready, all head outputs are stable.
- Flush: i_flush=1 at an edge forces EMPTY. Any accept in the same cycle is dropped. Flush has priority over accept and pop. The next cycle has o_valid=0, o_ready=1.
- Opcode (instr[6:0]) decode:
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> ctrl 000 (I), used=1.
  - 0100011 -> 001 (S), used=1.
  - 1100011 -> 010 (B), used=1.
  - 1101111 -> 011 (J), used=1.
  - 0110111, 0010111 -> 100 (U), used=1.
  - 0110011, 0111011, 0001111 -> ctrl 000, used=0.
  - Any other opcode -> ctrl 111, used=0, illegal=1. Ctrl 111 makes the extender output zero.
- o_imm is always instr[31:7], regardless of format.

Optional Feature:
- Macro: DECODE_IMM_STATS_EN.
- When defined, the block adds:
  - Ports i_stat_sel (3 bits) and o_stat_cnt (32 bits).
  - Six 32-bit saturating counters indexed 0=I, 1=S, 2=B, 3=J, 4=U, 5=illegal.
- Each counter increments on pop of a head entry of that class. Entries with used=0 and illegal=0 are not counted.
- Counters hold at 32'hFFFFFFFF and are not cleared by flush.
- o_stat_cnt is a combinational read of counter[i_stat_sel]. Selects 6 and 7 read 0.
- Counters reset to 0 on i_arst.
- When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then push 0x00500093 (addi) with pc 0x80000000 and i_ready=1 -> the next cycle shows o_valid=1, o_imm=25'h000A001, o_imm_ctrl=000, o_imm_used=1, o_pc=0x80000000.
- Push back-to-back 0x00112423, 0x00000463, 0x008000EF, 0x123450B7 -> ctrl sequence 001, 010, 011, 100 in order, one per cycle.
- Hold i_ready=0 and push 3 instructions -> o_ready drops after 2 accepted. The head stays stable on the first instruction. Release i_ready -> order preserved and the third instruction is accepted.
- Push 0x002081B3 (add) -> ctrl 000, used=0, illegal=0. Push 0x00000000 -> ctrl 111, illegal=1.
- Fill to FULL, then assert i_flush together with i_valid -> next cycle o_valid=0, o_ready=1, and the flushed and same-cycle inputs never appear. Assert i_arst mid-stream -> outputs immediately return to reset values.
- With DECODE_IMM_STATS_EN: pop 2 I-type, 1 B-type and 1 illegal instruction -> sel 0 reads 2, sel 2 reads 1, sel 5 reads 1, sel 6 reads 0.
